// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the 16x32 memory arbiter.
package mem_arb_pkg;

  localparam int MEM_DATA_W = 32;
  localparam int MEM_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_t;

endpackage

// File: rtl/mem16x32_arbiter_if.sv
// Requester-side bus of the memory arbiter: valid/ready request plus response pulse.
interface mem16x32_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input arbiter with one-hot grant; round-robin on ties by default,
// fixed priority (requester 0 wins) when MEM_ARB_FIXED_PRIO_EN is defined.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    gnt = 2'b00;
    if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end
`else
  always_comb begin
    gnt = req;
    // On a tie the requester that did not win last time goes first.
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end
  end
`endif

endmodule

// File: rtl/mem16x32_arbiter.sv
// Two-requester arbiter/sequencer for a 16x32 single-port memory with registered read.
// MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module mem16x32_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int NREQ   = 2
) (
  input  logic              CLK,
  input  logic              RST,
  mem16x32_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_q, state_d;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ready;
  logic [NREQ-1:0]   rsp;
  logic              win;
  logic              hs;
  logic              last_grant;

  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic              we_p1;
  logic              mem_we_p1;
  logic              owner_p1;

  rr_arb2 u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign win = gnt[1];

  always_comb begin
    state_d = state_q;
    ready   = '0;
    rsp     = '0;
    hs      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          ready   = gnt;
          hs      = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        rsp[owner_p1] = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.rsp_rdata = '0;
    if (state_q == RESP && !we_p1) begin
      bus.rsp_rdata = mem_rdata;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake stage: capture the winner's request; the write strobe lives for ISSUE only.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_p1   <= '0;
      wdata_p1  <= '0;
      we_p1     <= 1'b0;
      mem_we_p1 <= 1'b0;
      owner_p1  <= 1'b0;
    end else begin
      mem_we_p1 <= 1'b0;
      if (hs) begin
        addr_p1   <= bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
        wdata_p1  <= bus.req_wdata[int'(win)*DATA_W +: DATA_W];
        we_p1     <= bus.req_we[win];
        mem_we_p1 <= bus.req_we[win];
        owner_p1  <= win;
      end
    end
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign last_grant = 1'b0;
`else
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_grant <= 1'b1;
    end else if (state_q == RESP) begin
      last_grant <= owner_p1;
    end
  end
`endif

  assign mem_addr  = addr_p1;
  assign mem_wdata = wdata_p1;
  assign mem_we    = mem_we_p1;

endmodule

// File: tb/tb_mem16x32_arbiter.sv
// Bench for mem16x32_arbiter: memory model, transaction-level reference model, directed tests.
module tb_mem16x32_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = MEM_ADDR_W;
  localparam int DW = MEM_DATA_W;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  mem16x32_arbiter_if #(.NREQ(2), .ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_we;

  logic          v [2];
  logic          w [2];
  logic [AW-1:0] a [2];
  logic [DW-1:0] d [2];

  assign bus.req_valid = {v[1], v[0]};
  assign bus.req_we    = {w[1], w[0]};
  assign bus.req_addr  = {a[1], a[0]};
  assign bus.req_wdata = {d[1], d[0]};

  mem16x32_arbiter dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  // Single-port memory with registered read, cleared by the same reset.
  logic [DW-1:0] mem [16];
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  int total;
  int passed;
  int gnt_log[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic align();
    @(posedge CLK);
    #1;
  endtask

  // Reference: a transaction accepted in cycle N is issued in N+1 and answered in N+2;
  // the arbiter is free again in N+3.
  task automatic model_loop();
    int            since;
    logic          last;
    logic          t_we, t_own, win;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wd, erd;
    logic [DW-1:0] shadow [16];
    logic [1:0]    rv, er, ers;
    logic          ewe;
    since = -1;
    last  = 1'b1;
    t_we = 1'b0; t_own = 1'b0; t_addr = '0; t_wd = '0;
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    forever begin
      @(negedge CLK);
      rv = {v[1], v[0]};
      if (!RST) begin
        since = -1;
        last  = 1'b1;
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        chk("reset req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset mem_we", 32'(mem_we), 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
      end else begin
        er = 2'b00; ers = 2'b00; ewe = 1'b0; erd = '0; win = 1'b0;
        if (since < 0 && rv != 2'b00) begin
          if (rv == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            win = 1'b0;
`else
            win = !last;
`endif
          end else begin
            win = rv[1];
          end
          er[win] = 1'b1;
        end
        if (since == 1) ewe = t_we;
        if (since == 2) begin
          ers[t_own] = 1'b1;
          erd = t_we ? '0 : shadow[t_addr];
        end
        chk("model req_ready", 32'(bus.req_ready), 32'(er));
        chk("model rsp_valid", 32'(bus.rsp_valid), 32'(ers));
        chk("model rsp_rdata", bus.rsp_rdata, erd);
        chk("model mem_we", 32'(mem_we), 32'(ewe));
        if (since == 1 || since == 2) chk("model mem_addr", 32'(mem_addr), 32'(t_addr));
        if (since == 1 && t_we) begin
          chk("model mem_wdata", mem_wdata, t_wd);
          shadow[t_addr] = t_wd;
        end
        if (bus.req_ready != 2'b00) gnt_log.push_back(int'(bus.req_ready[1]));
        if (since == 2) begin
          last  = t_own;
          since = -1;
        end else if (since == 1) begin
          since = 2;
        end else if (er != 2'b00) begin
          t_own  = win;
          t_we   = w[win];
          t_addr = a[win];
          t_wd   = d[win];
          since  = 1;
        end
      end
    end
  endtask

  task automatic do_req(input int r, input logic we, input logic [AW-1:0] ad,
                        input logic [DW-1:0] wd);
    bit got;
    got  = 1'b0;
    w[r] = we;
    a[r] = ad;
    d[r] = wd;
    v[r] = 1'b1;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge CLK);
      if (bus.req_ready[r]) got = 1'b1;
    end
    if (!got) begin
      total++;
      $display("FAIL handshake r%0d: got no ready, expected ready within 30 cycles", r);
    end
    @(posedge CLK);
    #1;
    v[r] = 1'b0;
  endtask

  task automatic rd(input int r, input logic [AW-1:0] ad, output logic [DW-1:0] dat);
    bit got;
    got = 1'b0;
    dat = 'x;
    do_req(r, 1'b0, ad, '0);
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge CLK);
      if (bus.rsp_valid[r]) begin
        got = 1'b1;
        dat = bus.rsp_rdata;
      end
    end
    if (!got) begin
      total++;
      $display("FAIL response r%0d: got no rsp_valid, expected one within 10 cycles", r);
    end
    align();
  endtask

  initial begin
    logic [DW-1:0] dat;
    int nwe, rsp_at;
    int exp_g [4];
    total = 0;
    passed = 0;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; w[i] = 1'b0; a[i] = '0; d[i] = '0;
    end
    fork
      model_loop();
    join_none

    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;

    repeat (5) begin
      @(negedge CLK);
      chk("idle req_ready", 32'(bus.req_ready), 32'd0);
      chk("idle rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("idle mem_we", 32'(mem_we), 32'd0);
      chk("idle mem_addr", 32'(mem_addr), 32'd0);
    end
    align();

    do_req(0, 1'b1, 4'd3, 32'hDEADBEEF);
    nwe = 0;
    rsp_at = -1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (mem_we) nwe++;
      if (bus.rsp_valid[0]) rsp_at = i;
    end
    chk("write mem_we cycles", 32'(nwe), 32'd1);
    chk("write rsp latency", 32'(rsp_at), 32'd1);
    align();
    rd(0, 4'd3, dat);
    chk("read back addr3", dat, 32'hDEADBEEF);

    rd(1, 4'd15, dat);
    chk("unwritten addr15", dat, 32'h0);

    gnt_log.delete();
    fork
      begin
        do_req(0, 1'b0, 4'd1, '0);
        do_req(0, 1'b0, 4'd1, '0);
      end
      begin
        do_req(1, 1'b0, 4'd2, '0);
        do_req(1, 1'b0, 4'd2, '0);
      end
    join
    repeat (3) align();
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 1, 1};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    chk("tie grant count", 32'(gnt_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tie grant %0d", i), 32'(gnt_log.size() > i ? gnt_log[i] : -1), 32'(exp_g[i]));
    end

    do_req(1, 1'b1, 4'd5, 32'hCAFEF00D);
    RST = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      chk("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
    align();
    RST = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("post-abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("post-abort mem_we", 32'(mem_we), 32'd0);
    end
    align();
    rd(0, 4'd5, dat);
    chk("aborted write addr5", dat, 32'h0);

    gnt_log.delete();
    do_req(0, 1'b1, 4'd7, 32'h00001234);
    w[1] = 1'b1;
    a[1] = 4'd7;
    d[1] = 32'h00000BAD;
    v[1] = 1'b1;
    align();
    v[1] = 1'b0;
    repeat (3) align();
    chk("withdrawn grant count", 32'(gnt_log.size()), 32'd1);
    rd(1, 4'd7, dat);
    chk("withdrawn addr7", dat, 32'h00001234);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem16x32_arbiter.md
Name: mem16x32_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the shared 16x32 single-port synchronous memory.
- The memory has a registered read: data appears one clock after the address is sampled.
- The block accepts one read or write per grant using a valid/ready handshake and drives the memory port from registers.
- It returns a single-cycle response pulse to the winning requester.
- Sits between the two datapath masters and the memory instance.

Parameters:
- DATA_W, 32, data width; matches the memory width.
- ADDR_W, 4, address width; 16 words.
- NREQ, 2, number of requesters; fixed at 2, the parameter is for readability only.

Ports:
- CLK  input  1  clock; all flops on rising edge.
- RST  input  1  asynchronous active-low reset.
- req_valid  input  [NREQ-1:0]  request valid, per requester.
- req_ready  output  [NREQ-1:0]  request accepted this cycle.
- req_we  input  [NREQ-1:0]  1 = write, 0 = read.
- req_addr  input  [NREQ*ADDR_W-1:0]  packed request addresses; requester i uses slice i.
- req_wdata  input  [NREQ*DATA_W-1:0]  packed write data.
- rsp_valid  output  [NREQ-1:0]  one-cycle completion pulse.
- rsp_rdata  output  DATA_W  read data; valid while any rsp_valid bit is high.
- mem_addr  output  ADDR_W  to memory Address.
- mem_wdata  output  DATA_W  to memory Data_in.
- mem_we  output  1  to memory W_EN.
- mem_rdata  input  DATA_W  from memory Data_out.

Behaviour:
- Reset: RST is asynchronous, active-low; clock is CLK.
  - While RST is low: state=IDLE, all of req_ready, rsp_valid, mem_we and owner are 0.
  - mem_addr and mem_wdata are 0.
  - last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if any req_valid is set, select a winner. req_ready[winner]=1 combinationally in this cycle only; the handshake completes at the clock edge. Register addr, wdata, we and owner, then go to ISSUE. If no req_valid is set, stay in IDLE.
  - ISSUE: mem_we = latched we; mem_addr and mem_wdata hold the latched values. The memory samples at the end of this cycle. Next state is RESP.
  - RESP: rsp_valid[owner]=1 for exactly one cycle. rsp_rdata = mem_rdata for reads, 0 for writes. last_grant=owner. Next state is IDLE.
- Latency and throughput:
  - Handshake in cycle N gives ISSUE in N+1 and rsp_valid in N+2.
  - Peak throughput is one transaction per 3 cycles.
  - req_ready is 0 in ISSUE and RESP.
- Arbitration: round-robin. On a tie, grant the requester that is not last_grant. A single valid requester always wins.
- Requester rule: valid, we, addr and wdata stay stable until ready. The arbiter does not buffer unaccepted requests.
- mem_we is high only in ISSUE, so there are no spurious writes in IDLE or RESP.
- mem_addr is held through RESP. Write-then-read to the same address returns the new data because the transactions are serialized.
- Dropping req_valid before ready: the request is ignored and there is no side effect.
- RST asserted mid-transaction:
  - The FSM aborts to IDLE and no rsp_valid is issued.
  - The memory contents are cleared by the same RST.
- Reads of never-written addresses return 0 after reset.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, requester 0 always wins ties; last_grant is not implemented.
  - Undefined (default): round-robin as above.

Decomposition:
- Package mem_arb_pkg:
  - state enum type arb_state_t {IDLE, ISSUE, RESP};
  - localparams MEM_DATA_W=32 and MEM_ADDR_W=4.
- Optional sub-module rr_arb2: a two-input arbiter with inputs req[1:0] and last_grant, and outputs gnt[1:0] one-hot. The fixed-priority variant is selected by the macro inside rr_arb2.
- The top level instantiates rr_arb2 and the FSM. The memory is instantiated by the parent, not inside this block.

Test Plan:
- Reset then idle: after RST release, 5 idle cycles. Expect req_ready=0, rsp_valid=0, mem_we=0, mem_addr=0.
- Single write then read, requester 0: write addr 3 data 0xDEADBEEF; expect mem_we=1 for exactly 1 cycle and rsp_valid[0] 2 cycles after the handshake. Then read addr 3; expect rsp_rdata=0xDEADBEEF with rsp_valid[0].
- Tie, round-robin: both requesters hold valid continuously for reads of addr 1 and addr 2. Expect grants 0,1,0,1, one every 3 cycles, with rsp_valid alternating. Under MEM_ARB_FIXED_PRIO_EN, expect requester 0 every time.
- Read of unwritten address: requester 1 reads addr 15 after reset; expect rsp_rdata=0x00000000.
- Reset mid-op: requester 1 write is accepted and RST is pulled low during ISSUE. Expect no rsp_valid. After release, a read of that address returns 0 and the FSM is in IDLE.
- Withdrawn request: requester 1 asserts valid while the FSM is busy with requester 0, then deasserts before ready. Expect no grant to requester 1 and memory unchanged.
